// File: rtl/hmac_stream_pkg.sv
// Shared constants and state encoding for the HMAC stream adapter.
// 1312-bit HMAC input = 640-bit key (upper) || 672-bit message (lower).
package hmac_stream_pkg;
  localparam int WORD_W    = 32;
  localparam int IN_WORDS  = 41;
  localparam int OUT_WORDS = 8;
  localparam int KEY_BITS  = 640;
  localparam int MSG_BITS  = 672;
  localparam int IN_BITS   = KEY_BITS + MSG_BITS;
  localparam int OUT_BITS  = WORD_W * OUT_WORDS;
  localparam int CNT_W     = 6;

  typedef enum logic [1:0] {LOAD, START, WAIT, SEND} state_t;
endpackage

// File: rtl/stream_word_serializer.sv
// Holds a captured digest and streams it out MSW-first as valid/ready words.
// Ports:
//   clk, n_rst  clock, async active-low reset
//   i_clear     sync clear: drop valid, zero counter (digest kept)
//   i_load      capture i_digest and start streaming
//   i_digest    digest to capture
//   o_data      current word (top of the shift register)
//   o_valid     o_data valid
//   i_ready     consumer accepts o_data
//   o_last      accept of the final word this cycle
module stream_word_serializer #(
  parameter int WORD_W    = 32,
  parameter int OUT_WORDS = 8
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic                        i_clear,
  input  logic                        i_load,
  input  logic [WORD_W*OUT_WORDS-1:0] i_digest,
  output logic [WORD_W-1:0]           o_data,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic                        o_last
);
  localparam int BITS = WORD_W * OUT_WORDS;
  localparam int CW   = $clog2(OUT_WORDS);

  logic [BITS-1:0] r_digest;
  logic [CW-1:0]   r_cnt;
  logic            r_valid;
  logic            w_accept;
  logic            w_cnt_last;

  assign w_accept   = r_valid & i_ready;
  assign w_cnt_last = (r_cnt == CW'(OUT_WORDS - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_digest <= '0;
      r_cnt    <= '0;
      r_valid  <= 1'b0;
    end else if (i_clear) begin
      r_cnt    <= '0;
      r_valid  <= 1'b0;
    end else if (i_load) begin
      r_digest <= i_digest;
      r_cnt    <= '0;
      r_valid  <= 1'b1;
    end else if (w_accept) begin
      // Shift so the next word is always at the top; o_data stays put on stall.
      r_digest <= {r_digest[BITS-WORD_W-1:0], {WORD_W{1'b0}}};
      if (w_cnt_last) begin
        r_cnt   <= '0;
        r_valid <= 1'b0;
      end else begin
        r_cnt   <= r_cnt + 1'b1;
      end
    end
  end

  assign o_data  = r_digest[BITS-1 -: WORD_W];
  assign o_valid = r_valid;
  assign o_last  = w_accept & w_cnt_last;
endmodule

// File: rtl/hmac_stream_adapter.sv
// Host front end for the 164-byte HMAC-SHA256 core: packs 41 input words
// into the 1312-bit key||message vector, pulses the core start, captures the
// digest and returns it as 8 words.
// Ports:
//   clk, n_rst                  clock, async active-low reset
//   in_data/in_valid/in_ready   input word stream (accepted only in LOAD)
//   abort                       sync return to LOAD, counters cleared
//   hmac_data, hmac_enable      core input vector and one-cycle start
//   hmac_hash, hmac_hash_done   core digest and its strobe
//   out_data/out_valid/out_ready digest word stream
//   busy                        high outside LOAD
module hmac_stream_adapter
  import hmac_stream_pkg::*;
(
  input  logic                clk,
  input  logic                n_rst,
  input  logic [WORD_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                abort,
  output logic [IN_BITS-1:0]  hmac_data,
  output logic                hmac_enable,
  input  logic [OUT_BITS-1:0] hmac_hash,
  input  logic                hmac_hash_done,
  output logic [WORD_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy
);
  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_in_cnt;
  logic [IN_BITS-1:0] r_hmac_data;
  logic               r_in_ready;
  logic               w_in_accept;
  logic               w_in_last;
  logic               w_capture;
  logic               w_out_last;

  // r_in_ready mirrors LOAD but is held low during reset.
  assign w_in_accept = in_valid & r_in_ready & ~abort;
  assign w_in_last   = w_in_accept & (r_in_cnt == CNT_W'(IN_WORDS - 1));
  // Done strobes outside WAIT (including the START cycle) are ignored.
  assign w_capture   = (r_state == WAIT) & hmac_hash_done & ~abort;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= LOAD;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      LOAD:    if (w_in_last)  w_next = START;
      START:                   w_next = WAIT;
      WAIT:    if (w_capture)  w_next = SEND;
      SEND:    if (w_out_last) w_next = LOAD;
      default:                 w_next = LOAD;
    endcase
    if (abort) w_next = LOAD;
  end

  always_comb begin
    hmac_enable = (r_state == START);
    busy        = (r_state != LOAD);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_in_cnt    <= '0;
      r_hmac_data <= '0;
      r_in_ready  <= 1'b0;
    end else begin
      r_in_ready <= (w_next == LOAD);
      if (abort) begin
        r_in_cnt <= '0;
      end else if (w_in_accept) begin
        // Left shift: first word ends up as the key MSW.
        r_hmac_data <= {r_hmac_data[IN_BITS-WORD_W-1:0], in_data};
        r_in_cnt    <= w_in_last ? '0 : r_in_cnt + 1'b1;
      end
    end
  end

  assign hmac_data = r_hmac_data;
  assign in_ready  = r_in_ready;

  stream_word_serializer #(
    .WORD_W    (WORD_W),
    .OUT_WORDS (OUT_WORDS)
  ) u_ser (
    .clk      (clk),
    .n_rst    (n_rst),
    .i_clear  (abort),
    .i_load   (w_capture),
    .i_digest (hmac_hash),
    .o_data   (out_data),
    .o_valid  (out_valid),
    .i_ready  (out_ready),
    .o_last   (w_out_last)
  );
endmodule

// File: tb/tb_hmac_stream_adapter.sv
module tb_hmac_stream_adapter;
  logic          clk = 1'b0;
  logic          n_rst = 1'b1;
  logic [31:0]   in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          abort = 1'b0;
  logic [1311:0] hmac_data;
  logic          hmac_enable;
  logic [255:0]  hmac_hash = '0;
  logic          hmac_hash_done = 1'b0;
  logic [31:0]   out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_acc = -1;
  int en_cnt = 0;
  int en_cyc = -1;
  logic [31:0] oq[$];

  hmac_stream_adapter dut (
    .clk(clk), .n_rst(n_rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .abort(abort), .hmac_data(hmac_data),
    .hmac_enable(hmac_enable), .hmac_hash(hmac_hash),
    .hmac_hash_done(hmac_hash_done), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_valid && in_ready) last_acc <= cyc;
    if (hmac_enable) begin
      en_cnt <= en_cnt + 1;
      en_cyc <= cyc;
    end
    if (out_valid && out_ready) oq.push_back(out_data);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [31:0] base, input int first, input int n, input bit gap);
    for (int k = first; k < first + n; k++) begin
      if (gap) begin
        in_valid = 1'b0;
        step();
      end
      in_valid = 1'b1;
      in_data  = base + 32'(k);
      step();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int e0;
    int idx;
    // Reset asserted mid-cycle: outputs clear without a clock edge.
    #20 n_rst = 1'b0;
    #1;
    chk("rst_in_ready",  64'(in_ready), 64'(0));
    chk("rst_enable",    64'(hmac_enable), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_busy",      64'(busy), 64'(0));
    chk("rst_hmac_zero", 64'(|hmac_data), 64'(0));
    chk("rst_out_data",  64'(out_data), 64'(0));
    #11 n_rst = 1'b1;
    step();
    chk("idle_in_ready", 64'(in_ready), 64'(1));
    chk("idle_busy",     64'(busy), 64'(0));
    step(); step(); step();
    chk("idle_no_enable", 64'(en_cnt), 64'(0));

    // Full load, valid held high.
    load(32'h0, 0, 41, 1'b0);
    chk("full_enable_hi", 64'(hmac_enable), 64'(1));
    chk("full_in_ready",  64'(in_ready), 64'(0));
    chk("full_busy",      64'(busy), 64'(1));
    step();
    chk("full_enable_lo", 64'(hmac_enable), 64'(0));
    chk("full_en_lat",    64'(en_cyc - last_acc), 64'(1));
    chk("full_en_once",   64'(en_cnt), 64'(1));
    chk("full_w0",        64'(hmac_data[1311:1280]), 64'(32'h0));
    chk("full_w20",       64'(hmac_data[671:640]), 64'(32'h14));
    chk("full_w40",       64'(hmac_data[31:0]), 64'(32'h28));
    step(); step();
    chk("wait_no_valid",  64'(out_valid), 64'(0));
    chk("wait_in_ready",  64'(in_ready), 64'(0));

    // Digest return with alternating backpressure.
    for (int i = 0; i < 8; i++) hmac_hash[255-32*i -: 32] = 32'h11111111 * 32'(i);
    hmac_hash_done = 1'b1;
    step();
    hmac_hash_done = 1'b0;
    hmac_hash = {8{32'hDEADBEEF}};
    chk("send_valid", 64'(out_valid), 64'(1));
    idx = 0;
    for (int c = 0; c < 15; c++) begin
      out_ready = (c % 2 == 0);
      chk($sformatf("bp_word_c%0d", c), 64'(out_data), 64'(32'h11111111 * 32'(idx)));
      step();
      if (c % 2 == 0) idx++;
    end
    out_ready = 1'b0;
    chk("bp_accepts",  64'(oq.size()), 64'(8));
    chk("bp_last",     64'(oq[7]), 64'(32'h77777777));
    chk("bp_in_ready", 64'(in_ready), 64'(1));
    chk("bp_out_valid",64'(out_valid), 64'(0));
    chk("bp_busy",     64'(busy), 64'(0));

    // Gapped input gives the same vector and a single start.
    e0 = en_cnt;
    load(32'h0, 0, 41, 1'b1);
    step();
    chk("gap_en_once", 64'(en_cnt - e0), 64'(1));
    chk("gap_en_lat",  64'(en_cyc - last_acc), 64'(1));
    chk("gap_w0",      64'(hmac_data[1311:1280]), 64'(32'h0));
    chk("gap_w40",     64'(hmac_data[31:0]), 64'(32'h28));

    // Abort in WAIT, then a late done must be ignored.
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abortw_busy",     64'(busy), 64'(0));
    chk("abortw_in_ready", 64'(in_ready), 64'(1));
    hmac_hash_done = 1'b1;
    step();
    hmac_hash_done = 1'b0;
    step();
    chk("late_done_valid", 64'(out_valid), 64'(0));
    chk("late_done_busy",  64'(busy), 64'(0));

    // Abort during load discards the partial vector.
    load(32'hB0000000, 0, 20, 1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    e0 = en_cnt;
    load(32'hA0000000, 0, 40, 1'b0);
    chk("abortl_no_enable", 64'(en_cnt - e0), 64'(0));
    chk("abortl_busy",      64'(busy), 64'(0));
    load(32'hA0000000, 40, 1, 1'b0);
    chk("abortl_enable", 64'(hmac_enable), 64'(1));
    // Done in the START cycle is ignored.
    hmac_hash_done = 1'b1;
    step();
    hmac_hash_done = 1'b0;
    chk("start_done_busy",  64'(busy), 64'(1));
    chk("abortl_w0",        64'(hmac_data[1311:1280]), 64'(32'hA0000000));
    chk("abortl_w20",       64'(hmac_data[671:640]), 64'(32'hA0000014));
    chk("abortl_w40",       64'(hmac_data[31:0]), 64'(32'hA0000028));
    step();
    chk("start_done_valid", 64'(out_valid), 64'(0));

    // Spurious done while in SEND must not overwrite the digest.
    for (int i = 0; i < 8; i++) hmac_hash[255-32*i -: 32] = 32'hC0000000 + 32'(i);
    hmac_hash_done = 1'b1;
    step();
    hmac_hash_done = 1'b0;
    hmac_hash = {8{32'h5A5A5A5A}};
    hmac_hash_done = 1'b1;
    step();
    hmac_hash_done = 1'b0;
    chk("spur_valid", 64'(out_valid), 64'(1));
    chk("spur_hold",  64'(out_data), 64'(32'hC0000000));
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("spur_word%0d", i), 64'(out_data), 64'(32'hC0000000 + 32'(i)));
      step();
    end
    out_ready = 1'b0;
    chk("spur_in_ready", 64'(in_ready), 64'(1));
    chk("spur_busy",     64'(busy), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
